// File: rtl/fst_mon_pkg.sv
// Shared types and constants for the fst run monitor: FSM state codes and
// active-low 7-segment glyph table.
package fst_mon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RUN     = 3'd2,
    HALTED  = 3'd3,
    TIMEOUT = 3'd4
  } mon_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index = hex value; bit0=a .. bit6=g, bit7=dp (kept off).
  localparam logic [7:0] SEG_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/fst_run_monitor_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg
  import fst_mon_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_GLYPH[nibble];
  end

endmodule

// File: rtl/fst_run_monitor.sv
// Run controller for the fst core: owns core reset, counts run cycles until
// halt or watchdog expiry, latches the halt PC and drives eight 7-seg digits.
module fst_run_monitor
  import fst_mon_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        disp_sel,
  input  logic        halting,
  input  logic [15:0] pc,
  output logic        core_reset_n,
  output logic        running,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_count,
  output logic [15:0] halt_pc,
  output logic [7:0]  seg_a,
  output logic [7:0]  seg_b,
  output logic [7:0]  seg_c,
  output logic [7:0]  seg_d,
  output logic [7:0]  seg_e,
  output logic [7:0]  seg_f,
  output logic [7:0]  seg_g,
  output logic [7:0]  seg_h
);

  localparam logic [31:0] HOLD_LAST = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] WDOG_LAST = TIMEOUT_CYCLES - 32'd1;
  localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 32'd0);

  mon_state_e  state_q, state_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [15:0] halt_pc_q, halt_pc_d;
  logic        core_reset_n_q, core_reset_n_d;
  logic        start_q;
  logic        auto_pend_q, auto_pend_d;
  logic        start_rise;

  logic [3:0]  nib    [8];
  logic [7:0]  glyph  [8];
  logic [7:0]  seg_d_arr [8];
  logic [7:0]  seg_q  [8];

  assign start_rise = start & ~start_q;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    cycle_count_d = cycle_count_q;
    halt_pc_d     = halt_pc_q;
    auto_pend_d   = auto_pend_q;

    unique case (state_q)
      IDLE: begin
        if ((AUTO_START && auto_pend_q) || start_rise) begin
          state_d     = HOLD;
          auto_pend_d = 1'b0;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = RUN;
        else                         hold_cnt_d = hold_cnt_q + 32'd1;
      end
      RUN: begin
        if (start_rise) begin
          state_d = HOLD;
        end else if (halting) begin
          halt_pc_d = pc;
          state_d   = HALTED;
        end else begin
          if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 32'd1;
          if (WDOG_EN && (cycle_count_q == WDOG_LAST)) begin
            halt_pc_d = pc;
            state_d   = TIMEOUT;
          end
        end
      end
      HALTED, TIMEOUT: begin
        if (start_rise) state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase

    // Any entry into HOLD starts a fresh run regardless of where it came from.
    if ((state_d == HOLD) && (state_q != HOLD)) begin
      hold_cnt_d    = '0;
      cycle_count_d = '0;
      halt_pc_d     = '0;
    end

    core_reset_n_d = (state_d == RUN) || (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      hold_cnt_q     <= '0;
      cycle_count_q  <= '0;
      halt_pc_q      <= '0;
      core_reset_n_q <= 1'b0;
      start_q        <= 1'b1;
      auto_pend_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      cycle_count_q  <= cycle_count_d;
      halt_pc_q      <= halt_pc_d;
      core_reset_n_q <= core_reset_n_d;
      start_q        <= start;
      auto_pend_q    <= auto_pend_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) nib[i] = '0;
    if (disp_sel) begin
      nib[0] = halt_pc_q[3:0];
      nib[1] = halt_pc_q[7:4];
      nib[2] = halt_pc_q[11:8];
      nib[3] = halt_pc_q[15:12];
      nib[4] = {1'b0, state_q};
    end else begin
      for (int unsigned i = 0; i < 8; i++) nib[i] = cycle_count_q[4*i +: 4];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_digit
    hex_to_seg u_hex (
      .nibble (nib[g]),
      .seg    (glyph[g])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      seg_d_arr[i] = (disp_sel && (i >= 5)) ? SEG_BLANK : glyph[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 8; i++) seg_q[i] <= SEG_BLANK;
    end else begin
      for (int unsigned i = 0; i < 8; i++) seg_q[i] <= seg_d_arr[i];
    end
  end

  assign core_reset_n = core_reset_n_q;
  assign running      = (state_q == RUN);
  assign done         = (state_q == HALTED);
  assign timeout      = (state_q == TIMEOUT);
  assign cycle_count  = cycle_count_q;
  assign halt_pc      = halt_pc_q;

  assign seg_a = seg_q[0];
  assign seg_b = seg_q[1];
  assign seg_c = seg_q[2];
  assign seg_d = seg_q[3];
  assign seg_e = seg_q[4];
  assign seg_f = seg_q[5];
  assign seg_g = seg_q[6];
  assign seg_h = seg_q[7];

endmodule

// File: tb/tb_fst_run_monitor.sv
// Directed bench for fst_run_monitor: instance A auto-starts with a 20-cycle
// watchdog, instance B waits for start with the watchdog disabled.
module tb_fst_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_rst_n, a_start, a_disp, a_halt;
  logic [15:0] a_pc;
  logic        a_crn, a_run, a_done, a_to;
  logic [31:0] a_cnt;
  logic [15:0] a_hpc;
  logic [7:0]  a_sa, a_sb, a_sc, a_sd, a_se, a_sf, a_sg, a_sh;

  logic        b_rst_n, b_start, b_disp, b_halt;
  logic [15:0] b_pc;
  logic        b_crn, b_run, b_done, b_to;
  logic [31:0] b_cnt;
  logic [15:0] b_hpc;
  logic [7:0]  b_sa, b_sb, b_sc, b_sd, b_se, b_sf, b_sg, b_sh;

  fst_run_monitor #(.RESET_CYCLES(4), .TIMEOUT_CYCLES(32'd20), .AUTO_START(1'b1)) dut_a (
    .clk(clk), .reset_n(a_rst_n), .start(a_start), .disp_sel(a_disp),
    .halting(a_halt), .pc(a_pc), .core_reset_n(a_crn), .running(a_run),
    .done(a_done), .timeout(a_to), .cycle_count(a_cnt), .halt_pc(a_hpc),
    .seg_a(a_sa), .seg_b(a_sb), .seg_c(a_sc), .seg_d(a_sd),
    .seg_e(a_se), .seg_f(a_sf), .seg_g(a_sg), .seg_h(a_sh)
  );

  fst_run_monitor #(.RESET_CYCLES(4), .TIMEOUT_CYCLES(32'd0), .AUTO_START(1'b0)) dut_b (
    .clk(clk), .reset_n(b_rst_n), .start(b_start), .disp_sel(b_disp),
    .halting(b_halt), .pc(b_pc), .core_reset_n(b_crn), .running(b_run),
    .done(b_done), .timeout(b_to), .cycle_count(b_cnt), .halt_pc(b_hpc),
    .seg_a(b_sa), .seg_b(b_sb), .seg_c(b_sc), .seg_d(b_sd),
    .seg_e(b_se), .seg_f(b_sf), .seg_g(b_sg), .seg_h(b_sh)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_rst_n = 1'b0; a_start = 1'b0; a_disp = 1'b0; a_halt = 1'b0; a_pc = 16'h0000;
    tick(2);
    checks++; if (a_crn !== 1'b0) begin errors++; $display("FAIL reset_crn: got %b exp 0", a_crn); end
    checks++; if ({a_run, a_done, a_to} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {a_run, a_done, a_to}); end
    checks++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0h exp 0", a_cnt); end
    checks++; if (a_hpc !== 16'h0) begin errors++; $display("FAIL reset_hpc: got %0h exp 0", a_hpc); end
    checks++; if ({a_sa, a_sd, a_se, a_sh} !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_segs: got %h exp ffffffff", {a_sa, a_sd, a_se, a_sh}); end
  endtask

  task automatic test_hold;
    a_rst_n = 1'b1;
    checks++; if (a_crn !== 1'b0) begin errors++; $display("FAIL hold_idle_crn: got %b exp 0", a_crn); end
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      checks++; if ({a_crn, a_run} !== 2'b00) begin errors++; $display("FAIL hold_cycle%0d: got crn/run %b exp 00", i, {a_crn, a_run}); end
    end
    tick(1);
    checks++; if ({a_crn, a_run} !== 2'b11) begin errors++; $display("FAIL hold_release: got crn/run %b exp 11", {a_crn, a_run}); end
    checks++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL hold_cnt0: got %0d exp 0", a_cnt); end
  endtask

  task automatic test_halt;
    tick(10);
    checks++; if (a_cnt !== 32'd10) begin errors++; $display("FAIL halt_precnt: got %0d exp 10", a_cnt); end
    a_halt = 1'b1; a_pc = 16'h01A3;
    tick(1);
    checks++; if (a_done !== 1'b1 || a_run !== 1'b0) begin errors++; $display("FAIL halt_done: got done/run %b exp 10", {a_done, a_run}); end
    checks++; if (a_cnt !== 32'd10) begin errors++; $display("FAIL halt_cnt: got %0d exp 10", a_cnt); end
    checks++; if (a_hpc !== 16'h01A3) begin errors++; $display("FAIL halt_pc: got %h exp 01a3", a_hpc); end
    checks++; if ({a_sa, a_sb, a_sh} !== 24'h88C0C0) begin errors++; $display("FAIL halt_cntdisp: got %h exp 88c0c0", {a_sa, a_sb, a_sh}); end
    a_halt = 1'b0; a_disp = 1'b1; a_pc = 16'hFFFF;
    tick(1);
    checks++; if ({a_sd, a_sc, a_sb, a_sa} !== 32'hC0F988B0) begin errors++; $display("FAIL halt_pcdisp: got %h exp c0f988b0", {a_sd, a_sc, a_sb, a_sa}); end
    checks++; if (a_se !== 8'hB0) begin errors++; $display("FAIL halt_statedisp: got %h exp b0", a_se); end
    checks++; if ({a_sh, a_sg, a_sf} !== 24'hFFFFFF) begin errors++; $display("FAIL halt_blankdisp: got %h exp ffffff", {a_sh, a_sg, a_sf}); end
    checks++; if (a_done !== 1'b1 || a_hpc !== 16'h01A3 || a_crn !== 1'b1) begin errors++; $display("FAIL halt_stay: got done %b hpc %h crn %b exp 1 01a3 1", a_done, a_hpc, a_crn); end
  endtask

  task automatic test_restart;
    a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
    checks++; if ({a_done, a_crn} !== 2'b00) begin errors++; $display("FAIL restart_hold: got done/crn %b exp 00", {a_done, a_crn}); end
    checks++; if (a_cnt !== 32'd0 || a_hpc !== 16'h0) begin errors++; $display("FAIL restart_clear: got cnt %0d hpc %h exp 0 0", a_cnt, a_hpc); end
    tick(3);
    checks++; if (a_crn !== 1'b0) begin errors++; $display("FAIL restart_crn4: got %b exp 0", a_crn); end
    tick(1);
    checks++; if ({a_crn, a_run} !== 2'b11) begin errors++; $display("FAIL restart_run: got crn/run %b exp 11", {a_crn, a_run}); end
  endtask

  task automatic test_timeout;
    a_pc = 16'h0BEE;
    tick(19);
    checks++; if (a_cnt !== 32'd19 || a_run !== 1'b1) begin errors++; $display("FAIL wdog_pre: got cnt %0d run %b exp 19 1", a_cnt, a_run); end
    tick(1);
    checks++; if ({a_to, a_run, a_crn} !== 3'b100) begin errors++; $display("FAIL wdog_flags: got to/run/crn %b exp 100", {a_to, a_run, a_crn}); end
    checks++; if (a_cnt !== 32'd20) begin errors++; $display("FAIL wdog_cnt: got %0d exp 20", a_cnt); end
    checks++; if (a_hpc !== 16'h0BEE) begin errors++; $display("FAIL wdog_pc: got %h exp 0bee", a_hpc); end
    tick(1);
    checks++; if ({a_se, a_sc, a_sa} !== 24'h998386) begin errors++; $display("FAIL wdog_disp: got %h exp 998386", {a_se, a_sc, a_sa}); end
    a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
    checks++; if (a_to !== 1'b0 || a_cnt !== 32'd0) begin errors++; $display("FAIL wdog_restart: got to %b cnt %0d exp 0 0", a_to, a_cnt); end
    tick(4);
    tick(19);
    checks++; if (a_cnt !== 32'd19) begin errors++; $display("FAIL wdog_race_pre: got %0d exp 19", a_cnt); end
    a_halt = 1'b1;
    tick(1);
    a_halt = 1'b0;
    checks++; if ({a_done, a_to} !== 2'b10) begin errors++; $display("FAIL wdog_race: got done/to %b exp 10", {a_done, a_to}); end
    checks++; if (a_cnt !== 32'd19) begin errors++; $display("FAIL wdog_race_cnt: got %0d exp 19", a_cnt); end
  endtask

  task automatic test_no_autostart;
    b_rst_n = 1'b0; b_start = 1'b1; b_disp = 1'b1; b_halt = 1'b0; b_pc = 16'h1234;
    tick(2);
    b_rst_n = 1'b1;
    tick(10);
    checks++; if ({b_crn, b_run, b_done, b_to} !== 4'b0000) begin errors++; $display("FAIL noauto_idle: got %b exp 0000", {b_crn, b_run, b_done, b_to}); end
    checks++; if ({b_se, b_sa, b_sf} !== 24'hC0C0FF) begin errors++; $display("FAIL noauto_disp: got %h exp c0c0ff", {b_se, b_sa, b_sf}); end
    b_start = 1'b0;
    tick(1);
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    checks++; if ({b_crn, b_run} !== 2'b00) begin errors++; $display("FAIL noauto_hold: got crn/run %b exp 00", {b_crn, b_run}); end
    tick(1);
    checks++; if (b_se !== 8'hF9) begin errors++; $display("FAIL noauto_holddisp: got %h exp f9", b_se); end
    tick(3);
    checks++; if ({b_crn, b_run} !== 2'b11) begin errors++; $display("FAIL noauto_run: got crn/run %b exp 11", {b_crn, b_run}); end
  endtask

  task automatic test_abort;
    tick(7);
    checks++; if (b_cnt !== 32'd7) begin errors++; $display("FAIL abort_pre: got %0d exp 7", b_cnt); end
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    checks++; if ({b_run, b_crn} !== 2'b00 || b_cnt !== 32'd0) begin errors++; $display("FAIL abort_hold: got run/crn %b cnt %0d exp 00 0", {b_run, b_crn}, b_cnt); end
    tick(4);
    checks++; if (b_run !== 1'b1 || b_cnt !== 32'd0) begin errors++; $display("FAIL abort_rerun: got run %b cnt %0d exp 1 0", b_run, b_cnt); end
  endtask

  task automatic test_async_reset;
    b_disp = 1'b0;
    tick(3);
    checks++; if (b_sa !== 8'hA4) begin errors++; $display("FAIL areset_pre: got %h exp a4", b_sa); end
    #2;
    b_rst_n = 1'b0;
    #1;
    checks++; if ({b_crn, b_run, b_done, b_to} !== 4'b0000) begin errors++; $display("FAIL areset_flags: got %b exp 0000", {b_crn, b_run, b_done, b_to}); end
    checks++; if (b_cnt !== 32'd0 || b_hpc !== 16'h0) begin errors++; $display("FAIL areset_regs: got cnt %0d hpc %h exp 0 0", b_cnt, b_hpc); end
    checks++; if ({b_sa, b_sb, b_sc, b_sd, b_se, b_sf, b_sg, b_sh} !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL areset_segs: got %h exp all ff", {b_sa, b_sb, b_sc, b_sd, b_se, b_sf, b_sg, b_sh}); end
    tick(1);
    b_rst_n = 1'b1;
  endtask

  initial begin
    b_rst_n = 1'b0; b_start = 1'b0; b_disp = 1'b0; b_halt = 1'b0; b_pc = 16'h0;
    test_reset;
    test_hold;
    test_halt;
    test_restart;
    test_timeout;
    test_no_autostart;
    test_abort;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fst_run_monitor.md
Name: fst_run_monitor

Overview:
Board-level run controller and result reader for the fst core. It owns the core's reset:
- holds the core in reset for a fixed number of cycles, then releases it;
- counts execution cycles until the core raises halting, or until a watchdog expires;
- latches the halt PC;
- drives the eight 7-seg digits with the cycle count or the halt PC/status.

It sits between the board reset/pushbutton and the fst instance, and is the synthesizable counterpart of the simulation run/halt checker.

Parameters:
RESET_CYCLES, 4, core reset hold length in clk cycles (>=1).
TIMEOUT_CYCLES, 32'd100_000_000, watchdog limit in run cycles; 0 disables the watchdog.
AUTO_START, 1, 1 = start a run automatically after reset_n release; 0 = wait for a start edge.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  synchronous, debounced run request; rising edge is significant
disp_sel  in  1  0 = show cycle count; 1 = show halt PC and state
halting  in  1  from core
pc  in  16  from core (pc_out)
core_reset_n  out  1  reset to core, active-low, registered
running  out  1  high in RUN
done  out  1  high in HALTED
timeout  out  1  high in TIMEOUT
cycle_count  out  32  run cycles counted
halt_pc  out  16  pc sampled at halt or timeout
seg_a..seg_h  out  8 each  digit patterns, active-low; bit0=a .. bit6=g, bit7=dp; seg_a is the least-significant digit

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE;
  - core_reset_n=0; running/done/timeout=0;
  - cycle_count=0; halt_pc=0; hold counter=0;
  - all seg_*=8'hFF (blank);
  - start_q=1, so a start held high through reset is not an edge.
- Edge detect: start_rise = start & ~start_q; start_q is a register.
- States (3-bit code): IDLE=0, HOLD=1, RUN=2, HALTED=3, TIMEOUT=4.
- IDLE:
  - core_reset_n=0.
  - Go to HOLD next cycle if AUTO_START=1, or on start_rise.
  - AUTO_START is consumed once per reset_n release.
- HOLD:
  - core_reset_n=0; hold counter counts 0..RESET_CYCLES-1.
  - At terminal count, go to RUN; core_reset_n becomes 1 on the same edge.
  - On entry, cycle_count, halt_pc and flags are cleared.
  - start_rise is ignored.
- RUN:
  - core_reset_n=1.
  - Each cycle with halting=0: cycle_count+1, saturating at 32'hFFFF_FFFF.
  - First cycle with halting=1: halt_pc<=pc; go to HALTED; no increment.
  - Watchdog: if TIMEOUT_CYCLES!=0, halting=0 and cycle_count==TIMEOUT_CYCLES-1, then increment, halt_pc<=pc, and go to TIMEOUT.
  - If halting and watchdog expiry coincide, halting wins.
  - start_rise in RUN aborts the run: go to HOLD (clears count).
- HALTED:
  - core_reset_n stays 1 (core frozen by itself); done=1.
  - start_rise goes to HOLD.
  - halting is ignored outside RUN.
- TIMEOUT:
  - core_reset_n=0 (core forced idle); timeout=1.
  - start_rise goes to HOLD.
- running/done/timeout are decoded from the registered state; no glitches.
- Display (registered, 1-cycle latency from cycle_count/halt_pc/state/disp_sel):
  - disp_sel=0: seg_h..seg_a = hex glyphs of cycle_count[31:0], nibble 7..0.
  - disp_sel=1: seg_d..seg_a = glyphs of halt_pc[15:12..3:0]; seg_e = glyph of the state code; seg_f..seg_h = 8'hFF.
  - dp is always off (bit7=1).
- Glyphs 0-F (active-low):
  - 0-7: C0, F9, A4, B0, 99, 92, 82, F8
  - 8-F: 80, 90, 88, 83, C6, A1, 86, 8E

Decomposition:
- Package fst_mon_pkg:
  - state enum (IDLE, HOLD, RUN, HALTED, TIMEOUT with the codes above);
  - SEG_BLANK=8'hFF;
  - 16-entry glyph constant array.
- One sub-module, hex_to_seg: 4-bit nibble -> 8-bit active-low pattern, combinational. Instantiated 8 times.

Test Plan:
1. AUTO_START=1, RESET_CYCLES=4, release reset_n at t0 -> core_reset_n low for exactly 4 cycles after IDLE, then 1; running=1.
2. Hold halting=0 for 10 RUN cycles, then halting=1 with pc=16'h01A3 -> cycle_count=10, halt_pc=16'h01A3, done=1. With disp_sel=1 one cycle later:
   - seg_a=8'hB0, seg_b=8'h88, seg_c=8'hF9, seg_d=8'hC0;
   - seg_e=8'hB0 (state 3);
   - seg_f..seg_h=8'hFF.
3. TIMEOUT_CYCLES=20, halting never asserted -> after 20 RUN cycles timeout=1, cycle_count=20, core_reset_n=0. Repeat with halting=1 on the 20th cycle -> done=1, timeout=0.
4. In HALTED, pulse start for 1 cycle -> HOLD, cycle_count=0, done=0, 4-cycle core reset, then RUN. Start held high across reset_n release -> no extra run.
5. AUTO_START=0 -> core_reset_n stays 0 and state stays IDLE indefinitely; first start pulse begins HOLD. start pulse mid-RUN at count 7 -> run aborted, count cleared.
6. Assert reset_n=0 mid-RUN -> outputs immediately (asynchronously) at reset values, all segs 8'hFF, core_reset_n=0.
